// File: rtl/cfg_loader_if.sv
// Handshake and shift-chain signal bundle for cfg_loader.
// The master side drives the request and serial bits; the slave side (the loader) drives the rest.
interface cfg_loader_if;
    logic start;
    logic abort;
    logic bit_in;
    logic bit_valid;
    logic bit_ready;
    logic sr_cfg;
    logic sr_shift;
    logic sr_clr;
    logic cfg_en;
    logic busy;
    logic err;

    modport master (
        output start, abort, bit_in, bit_valid,
        input  bit_ready, sr_cfg, sr_shift, sr_clr, cfg_en, busy, err
    );

    modport slave (
        input  start, abort, bit_in, bit_valid,
        output bit_ready, sr_cfg, sr_shift, sr_clr, cfg_en, busy, err
    );
endinterface

// File: rtl/cfg_loader.sv
// Serial configuration loader: clears the chain, shifts in LEN bits, then checks one even-parity bit.
// cfg_en is raised only after a load whose parity check succeeds.
module cfg_loader #(
    parameter int LEN = 8
) (
    input  logic         clk,
    input  logic         res,
    cfg_loader_if.slave  lif
);

    localparam int CW = $clog2(LEN + 1);

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        LOAD,
        PAR
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [CW-1:0] cnt_q;
    logic          acc_q;
    logic          cfg_en_q;
    logic          err_q;
    logic          sr_cfg_q;
    logic          sr_shift_q;

    logic          busy;
    logic          ready;
    logic          xfer;
    logic          last_bit;
    logic          par_bad;

    assign busy     = (state_q != IDLE);
    // An abort withdraws ready, so a same-cycle bit is never accepted by either side.
    assign ready    = ((state_q == LOAD) || (state_q == PAR)) && !lif.abort;
    assign xfer     = lif.bit_valid && ready;
    assign last_bit = (cnt_q == CW'(LEN - 1));
    assign par_bad  = acc_q ^ lif.bit_in;

    assign lif.bit_ready = ready;
    assign lif.busy      = busy;
    assign lif.sr_clr    = (state_q == CLEAR);
    assign lif.sr_cfg    = sr_cfg_q;
    assign lif.sr_shift  = sr_shift_q;
    assign lif.cfg_en    = cfg_en_q;
    assign lif.err       = err_q;

    // NOTE: sequential state uses <= so every register samples pre-edge values together.
    always_ff @(posedge clk) begin
        if (res) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: state_d gets its default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (lif.start) state_d = CLEAR;
            CLEAR:   state_d = LOAD;
            LOAD:    if (xfer && last_bit) state_d = PAR;
            PAR:     if (xfer) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (busy && lif.abort) begin
            state_d = CLEAR;
        end
    end

    always_ff @(posedge clk) begin
        if (res) begin
            cnt_q      <= '0;
            acc_q      <= 1'b0;
            cfg_en_q   <= 1'b0;
            err_q      <= 1'b0;
            sr_cfg_q   <= 1'b0;
            sr_shift_q <= 1'b0;
        end else begin
            sr_shift_q <= 1'b0;
            unique case (state_q)
                CLEAR: begin
                    cnt_q    <= '0;
                    acc_q    <= 1'b0;
                    cfg_en_q <= 1'b0;
                    err_q    <= 1'b0;
                end
                LOAD: begin
                    if (xfer) begin
                        cnt_q      <= cnt_q + 1'b1;
                        acc_q      <= acc_q ^ lif.bit_in;
                        sr_cfg_q   <= lif.bit_in;
                        sr_shift_q <= 1'b1;
                    end
                end
                PAR: begin
                    if (xfer) begin
                        cfg_en_q <= ~par_bad;
                        err_q    <= par_bad;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cfg_loader.sv
// Directed bench for cfg_loader (LEN=8): loads, parity, abort, reset, gaps and ignored starts.
module tb_cfg_loader;

    logic clk = 1'b0;
    logic res = 1'b1;
    int   total = 0;
    int   bad = 0;

    int          shift_cnt = 0;
    int          clr_cnt = 0;
    logic [31:0] hist = '0;

    cfg_loader_if lif ();

    cfg_loader #(.LEN(8)) dut (
        .clk (clk),
        .res (res),
        .lif (lif.slave)
    );

    always #5 clk = ~clk;

    // Registered outputs are stable mid-cycle, so the falling edge sees each pulse exactly once.
    always @(negedge clk) begin
        if (lif.sr_shift === 1'b1) begin
            shift_cnt++;
            hist = {hist[30:0], lif.sr_cfg};
        end
        if (lif.sr_clr === 1'b1) clr_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        lif.start = 1'b1;
        tick();
        lif.start = 1'b0;
    endtask

    // Leaves bit_valid high so consecutive calls give back-to-back transfers.
    task automatic send_bit(input logic b);
        lif.bit_in    = b;
        lif.bit_valid = 1'b1;
        for (int i = 0; i < 20 && lif.bit_ready !== 1'b1; i++) tick();
        if (lif.bit_ready !== 1'b1) begin
            total++; bad++;
            $display("FAIL send_bit_timeout: bit_ready=%b required 1", lif.bit_ready);
        end else begin
            tick();
        end
    endtask

    task automatic send_word(input logic [7:0] d, input logic par, input int max_gap);
        for (int i = 7; i >= 0; i--) begin
            send_bit(d[i]);
            if (max_gap > 0) begin
                lif.bit_valid = 1'b0;
                repeat ($urandom_range(0, max_gap)) tick();
            end
        end
        send_bit(par);
        lif.bit_valid = 1'b0;
    endtask

    task automatic test_reset();
        lif.start = 1'b0; lif.abort = 1'b0; lif.bit_in = 1'b0; lif.bit_valid = 1'b0;
        res = 1'b1;
        repeat (2) tick();
        total++; if (lif.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", lif.busy); end
        total++; if (lif.bit_ready !== 1'b0) begin bad++; $display("FAIL reset_ready: got %b want 0", lif.bit_ready); end
        total++; if (lif.cfg_en !== 1'b0) begin bad++; $display("FAIL reset_cfg_en: got %b want 0", lif.cfg_en); end
        total++; if (lif.err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", lif.err); end
        total++; if (lif.sr_shift !== 1'b0) begin bad++; $display("FAIL reset_sr_shift: got %b want 0", lif.sr_shift); end
        total++; if (lif.sr_clr !== 1'b0) begin bad++; $display("FAIL reset_sr_clr: got %b want 0", lif.sr_clr); end
        total++; if (lif.sr_cfg !== 1'b0) begin bad++; $display("FAIL reset_sr_cfg: got %b want 0", lif.sr_cfg); end
        res = 1'b0;
        tick();
    endtask

    task automatic test_good_load();
        int s0 = shift_cnt;
        pulse_start();
        total++; if (lif.sr_clr !== 1'b1) begin bad++; $display("FAIL good_clr: got %b want 1", lif.sr_clr); end
        total++; if (lif.busy !== 1'b1) begin bad++; $display("FAIL good_busy_clear: got %b want 1", lif.busy); end
        total++; if (lif.bit_ready !== 1'b0) begin bad++; $display("FAIL good_ready_clear: got %b want 0", lif.bit_ready); end
        send_word(8'b10110010, 1'b0, 0);
        total++; if (shift_cnt - s0 !== 8) begin bad++; $display("FAIL good_shifts: got %0d want 8", shift_cnt - s0); end
        total++; if (hist[7:0] !== 8'hB2) begin bad++; $display("FAIL good_seq: got %h want b2", hist[7:0]); end
        total++; if (lif.cfg_en !== 1'b1) begin bad++; $display("FAIL good_cfg_en: got %b want 1", lif.cfg_en); end
        total++; if (lif.err !== 1'b0) begin bad++; $display("FAIL good_err: got %b want 0", lif.err); end
        total++; if (lif.busy !== 1'b0) begin bad++; $display("FAIL good_busy_end: got %b want 0", lif.busy); end
        tick();
        total++; if (lif.sr_shift !== 1'b0) begin bad++; $display("FAIL good_no_par_shift: got %b want 0", lif.sr_shift); end
    endtask

    task automatic test_bad_parity();
        int s0 = shift_cnt;
        pulse_start();
        send_word(8'b10110010, 1'b1, 0);
        total++; if (shift_cnt - s0 !== 8) begin bad++; $display("FAIL par_shifts: got %0d want 8", shift_cnt - s0); end
        total++; if (lif.err !== 1'b1) begin bad++; $display("FAIL par_err: got %b want 1", lif.err); end
        total++; if (lif.cfg_en !== 1'b0) begin bad++; $display("FAIL par_cfg_en: got %b want 0", lif.cfg_en); end
        total++; if (lif.busy !== 1'b0) begin bad++; $display("FAIL par_busy: got %b want 0", lif.busy); end
        total++; if (lif.bit_ready !== 1'b0) begin bad++; $display("FAIL par_ready: got %b want 0", lif.bit_ready); end
    endtask

    task automatic test_abort();
        int s0 = shift_cnt;
        int s1;
        pulse_start();
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
        lif.abort  = 1'b1;
        lif.bit_in = 1'b1;
        #1;
        total++; if (lif.bit_ready !== 1'b0) begin bad++; $display("FAIL abort_ready: got %b want 0", lif.bit_ready); end
        tick();
        lif.abort = 1'b0;
        lif.bit_valid = 1'b0;
        total++; if (lif.sr_clr !== 1'b1) begin bad++; $display("FAIL abort_clr: got %b want 1", lif.sr_clr); end
        total++; if (lif.busy !== 1'b1) begin bad++; $display("FAIL abort_busy: got %b want 1", lif.busy); end
        total++; if (shift_cnt - s0 !== 3) begin bad++; $display("FAIL abort_shifts: got %0d want 3", shift_cnt - s0); end
        s1 = shift_cnt;
        send_word(8'hA5, 1'b0, 0);
        total++; if (shift_cnt - s1 !== 8) begin bad++; $display("FAIL abort_reload_shifts: got %0d want 8", shift_cnt - s1); end
        total++; if (hist[7:0] !== 8'hA5) begin bad++; $display("FAIL abort_reload_seq: got %h want a5", hist[7:0]); end
        total++; if (lif.cfg_en !== 1'b1) begin bad++; $display("FAIL abort_reload_cfg_en: got %b want 1", lif.cfg_en); end
    endtask

    task automatic test_mid_reset();
        pulse_start();
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        lif.bit_valid = 1'b0;
        res = 1'b1;
        lif.start = 1'b1;
        tick();
        res = 1'b0;
        lif.start = 1'b0;
        total++; if (lif.busy !== 1'b0) begin bad++; $display("FAIL mrst_busy: got %b want 0", lif.busy); end
        total++; if (lif.bit_ready !== 1'b0) begin bad++; $display("FAIL mrst_ready: got %b want 0", lif.bit_ready); end
        total++; if (lif.sr_shift !== 1'b0) begin bad++; $display("FAIL mrst_sr_shift: got %b want 0", lif.sr_shift); end
        total++; if (lif.sr_cfg !== 1'b0) begin bad++; $display("FAIL mrst_sr_cfg: got %b want 0", lif.sr_cfg); end
        total++; if (lif.sr_clr !== 1'b0) begin bad++; $display("FAIL mrst_sr_clr: got %b want 0", lif.sr_clr); end
        total++; if (lif.cfg_en !== 1'b0) begin bad++; $display("FAIL mrst_cfg_en: got %b want 0", lif.cfg_en); end
        total++; if (lif.err !== 1'b0) begin bad++; $display("FAIL mrst_err: got %b want 0", lif.err); end
        pulse_start();
        send_word(8'h3C, 1'b0, 0);
        total++; if (hist[7:0] !== 8'h3C) begin bad++; $display("FAIL mrst_reload_seq: got %h want 3c", hist[7:0]); end
        total++; if (lif.cfg_en !== 1'b1) begin bad++; $display("FAIL mrst_reload_cfg_en: got %b want 1", lif.cfg_en); end
    endtask

    task automatic test_gaps();
        int s0 = shift_cnt;
        lif.bit_valid = 1'b1;
        repeat (3) tick();
        lif.bit_valid = 1'b0;
        total++; if (shift_cnt - s0 !== 0) begin bad++; $display("FAIL gap_idle_shifts: got %0d want 0", shift_cnt - s0); end
        total++; if (lif.busy !== 1'b0) begin bad++; $display("FAIL gap_idle_busy: got %b want 0", lif.busy); end
        pulse_start();
        send_word(8'h6B, 1'b1, 3);
        total++; if (shift_cnt - s0 !== 8) begin bad++; $display("FAIL gap_shifts: got %0d want 8", shift_cnt - s0); end
        total++; if (hist[7:0] !== 8'h6B) begin bad++; $display("FAIL gap_seq: got %h want 6b", hist[7:0]); end
        total++; if (lif.cfg_en !== 1'b1) begin bad++; $display("FAIL gap_cfg_en: got %b want 1", lif.cfg_en); end
        total++; if (lif.err !== 1'b0) begin bad++; $display("FAIL gap_err: got %b want 0", lif.err); end
    endtask

    task automatic test_start_ignored();
        int s0 = shift_cnt;
        int c0 = clr_cnt;
        pulse_start();
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
        lif.bit_valid = 1'b0;
        pulse_start();
        send_bit(1'b0); send_bit(1'b0); send_bit(1'b0); send_bit(1'b0);
        lif.bit_valid = 1'b0;
        pulse_start();
        total++; if (lif.bit_ready !== 1'b1) begin bad++; $display("FAIL sti_par_ready: got %b want 1", lif.bit_ready); end
        send_bit(1'b0);
        lif.bit_valid = 1'b0;
        total++; if (clr_cnt - c0 !== 1) begin bad++; $display("FAIL sti_clr_count: got %0d want 1", clr_cnt - c0); end
        total++; if (shift_cnt - s0 !== 8) begin bad++; $display("FAIL sti_shifts: got %0d want 8", shift_cnt - s0); end
        total++; if (hist[7:0] !== 8'hF0) begin bad++; $display("FAIL sti_seq: got %h want f0", hist[7:0]); end
        total++; if (lif.cfg_en !== 1'b1) begin bad++; $display("FAIL sti_cfg_en: got %b want 1", lif.cfg_en); end
    endtask

    task automatic test_abort_idle();
        lif.abort = 1'b1;
        tick();
        lif.abort = 1'b0;
        total++; if (lif.busy !== 1'b0) begin bad++; $display("FAIL aid_busy: got %b want 0", lif.busy); end
        total++; if (lif.sr_clr !== 1'b0) begin bad++; $display("FAIL aid_clr: got %b want 0", lif.sr_clr); end
        total++; if (lif.cfg_en !== 1'b1) begin bad++; $display("FAIL aid_cfg_en: got %b want 1", lif.cfg_en); end
        lif.start = 1'b1;
        lif.abort = 1'b1;
        tick();
        lif.start = 1'b0;
        lif.abort = 1'b0;
        total++; if (lif.sr_clr !== 1'b1) begin bad++; $display("FAIL sa_clr: got %b want 1", lif.sr_clr); end
        total++; if (lif.busy !== 1'b1) begin bad++; $display("FAIL sa_busy: got %b want 1", lif.busy); end
        tick();
        total++; if (lif.cfg_en !== 1'b0) begin bad++; $display("FAIL sa_cfg_en_cleared: got %b want 0", lif.cfg_en); end
        total++; if (lif.bit_ready !== 1'b1) begin bad++; $display("FAIL sa_load_ready: got %b want 1", lif.bit_ready); end
    endtask

    initial begin
        test_reset();
        test_good_load();
        test_bad_parity();
        test_abort();
        test_mid_reset();
        test_gaps();
        test_start_ignored();
        test_abort_idle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
